// File: rtl/dds_wave_gen.sv
// dds_wave_gen -- direct-digital-synthesis waveform generator.
//
// A phase accumulator (tuning word ftw, phase_offset) feeds a 3-stage pipe.
// The pipe produces sine (from a quarter-wave LUT), triangle, square or
// sawtooth samples. Samples are unsigned offset binary with midscale
// 2^(OUT_WIDTH-1) and leave through a valid/ready port.
//
// Ports
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   enable              admit one new sample this cycle (when not stalled)
//   phase_sync          with an admitted sample: treat accumulator as 0
//   ftw, phase_offset   phase step per sample / constant phase added
//   mode                00 sine, 01 triangle, 10 square, 11 sawtooth
//   out_sample/out_valid/out_ready   output stream, standard valid/ready
//
// dds_quarter_sine_rom -- combinational quarter-wave magnitude table,
// L[k] = round((2^(W-1)-1) * sin(pi/2 * (k+0.5)/N)).

module dds_quarter_sine_rom #(
  parameter int OUT_WIDTH = 8,
  parameter int LUT_ADDR  = 6
) (
  input  logic [LUT_ADDR-1:0]  addr,
  output logic [OUT_WIDTH-2:0] mag
);
  localparam int N = 1 << LUT_ADDR;

  generate
    if (OUT_WIDTH == 8 && LUT_ADDR == 6) begin : g_fixed
      // Precomputed for the default geometry (127 * sin(pi/128 * (k+0.5))).
      localparam logic [6:0] TBL [64] = '{
        7'd2,   7'd5,   7'd8,   7'd11,  7'd14,  7'd17,  7'd20,  7'd23,
        7'd26,  7'd29,  7'd32,  7'd35,  7'd38,  7'd41,  7'd44,  7'd47,
        7'd50,  7'd53,  7'd56,  7'd58,  7'd61,  7'd64,  7'd67,  7'd69,
        7'd72,  7'd74,  7'd77,  7'd79,  7'd82,  7'd84,  7'd86,  7'd89,
        7'd91,  7'd93,  7'd95,  7'd97,  7'd99,  7'd101, 7'd103, 7'd105,
        7'd106, 7'd108, 7'd110, 7'd111, 7'd113, 7'd114, 7'd115, 7'd117,
        7'd118, 7'd119, 7'd120, 7'd121, 7'd122, 7'd123, 7'd124, 7'd124,
        7'd125, 7'd125, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127, 7'd127
      };
      assign mag = TBL[addr];
    end else begin : g_calc
      // Other geometries: entries are constant-folded at elaboration.
      function automatic logic [OUT_WIDTH-2:0] entry(input int k);
        real amp, x;
        amp = real'((1 << (OUT_WIDTH - 1)) - 1);
        x   = amp * $sin(3.14159265358979 * (real'(k) + 0.5) / (2.0 * real'(N)));
        return (OUT_WIDTH-1)'($rtoi(x + 0.5));
      endfunction

      logic [OUT_WIDTH-2:0] tbl [N];
      for (genvar k = 0; k < N; k++) begin : g_ent
        assign tbl[k] = entry(k);
      end
      assign mag = tbl[addr];
    end
  endgenerate
endmodule

module dds_wave_gen #(
  parameter int OUT_WIDTH   = 8,
  parameter int PHASE_WIDTH = 16,
  parameter int LUT_ADDR    = 6
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   phase_sync,
  input  logic [PHASE_WIDTH-1:0] ftw,
  input  logic [PHASE_WIDTH-1:0] phase_offset,
  input  logic [1:0]             mode,
  output logic [OUT_WIDTH-1:0]   out_sample,
  output logic                   out_valid,
  input  logic                   out_ready
);
  localparam int W      = OUT_WIDTH;
  localparam int P      = PHASE_WIDTH;
  localparam int A      = LUT_ADDR;
  localparam int STAGES = 3;
  localparam logic [W-1:0] MID = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    MODE_SINE = 2'b00,
    MODE_TRI  = 2'b01,
    MODE_SQR  = 2'b10,
    MODE_SAW  = 2'b11
  } mode_e;

  typedef struct packed {
    logic [P-1:0] ph;
    mode_e        mode;
  } s1_t;

  typedef struct packed {
    logic         sine;   // select LUT path in S3
    logic         neg;    // lower half-cycle: subtract magnitude
    logic [A-1:0] addr;   // already mirrored for quadrants 1 and 3
    logic [W-1:0] alt;    // triangle/square/sawtooth result
  } s2_t;

  logic              stall, adm;
  logic [P-1:0]      acc, base, ph;
  logic [STAGES:1]   vld_pipe;
  s1_t               s1;
  s2_t               s2, s2_d;
  logic [W-2:0]      lut_mag;
  logic [W-1:0]      sine_val;

  // Everything, accumulator included, freezes while the consumer back-pressures.
  assign stall = out_valid & ~out_ready;
  assign adm   = enable & ~stall;

  assign base = phase_sync ? '0 : acc;
  assign ph   = base + phase_offset;

  // ---- accumulator + S1 ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc     <= '0;
      s1      <= '0;
    end else if (!stall) begin
      if (adm) acc <= base + ftw;
      s1.ph   <= ph;
      s1.mode <= mode_e'(mode);
    end
  end

  // ---- S2: quadrant/address decode, arithmetic waveforms ----
  logic [1:0]   q;
  logic [A-1:0] a;
  logic [W-1:0] t;

  always_comb begin
    q    = s1.ph[P-1:P-2];
    a    = s1.ph[P-3 -: A];
    t    = s1.ph[P-2 -: W];
    s2_d = '0;
    s2_d.sine = (s1.mode == MODE_SINE);
    s2_d.neg  = q[1];
    // N-1-a is the bitwise complement of a in A bits.
    s2_d.addr = q[0] ? ~a : a;
    case (s1.mode)
      MODE_TRI: s2_d.alt = s1.ph[P-1] ? ~t : t;
      MODE_SQR: s2_d.alt = {W{~s1.ph[P-1]}};
      MODE_SAW: s2_d.alt = s1.ph[P-1 -: W];
      default:  s2_d.alt = '0;
    endcase
  end

  // Lower phase bits are truncated by design.
  logic unused_ph;
  assign unused_ph = ^s1.ph;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)       s2 <= '0;
    else if (!stall) s2 <= s2_d;
  end

  // ---- S3: LUT read, mirror/sign, output register ----
  dds_quarter_sine_rom #(.OUT_WIDTH(W), .LUT_ADDR(A)) u_rom (
    .addr (s2.addr),
    .mag  (lut_mag)
  );

  // Magnitude is at most 2^(W-1)-1, so mid +/- mag never wraps.
  assign sine_val = s2.neg ? (MID - {1'b0, lut_mag}) : (MID + {1'b0, lut_mag});

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_pipe   <= '0;
      out_sample <= MID;
    end else if (!stall) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], adm};
      // Bubbles leave out_sample at its last value.
      if (vld_pipe[2]) out_sample <= s2.sine ? sine_val : s2.alt;
    end
  end

  assign out_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_dds_wave_gen.sv
module tb_dds_wave_gen;
  logic        clock = 1'b0;
  logic        reset, enable, phase_sync, out_ready, out_valid;
  logic [15:0] ftw, phase_offset;
  logic [1:0]  mode;
  logic [7:0]  out_sample;

  int errors = 0;
  int checks = 0;

  int exp_q[$];
  int got[$];
  int model_acc;
  int n_adm;
  bit stall_prev;
  int held;
  int idx;

  localparam real PI = 3.14159265358979;

  always #5 clock = ~clock;

  dds_wave_gen #(.OUT_WIDTH(8), .PHASE_WIDTH(16), .LUT_ADDR(6)) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .phase_sync   (phase_sync),
    .ftw          (ftw),
    .phase_offset (phase_offset),
    .mode         (mode),
    .out_sample   (out_sample),
    .out_valid    (out_valid),
    .out_ready    (out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Reference waveform straight from the mathematical definition.
  function automatic int ref_sample(input int m, input int ph);
    int  q, a, k, l;
    real s;
    case (m)
      0: begin
        q = ph / 16384;
        a = (ph / 256) % 64;
        k = (q % 2 == 1) ? 63 - a : a;
        s = 127.0 * $sin(PI / 2.0 * (real'(k) + 0.5) / 64.0);
        l = $rtoi(s + 0.5);
        return (q < 2) ? 128 + l : 128 - l;
      end
      1: begin
        k = (ph / 128) % 256;
        return (ph >= 32768) ? 255 - k : k;
      end
      2: return (ph >= 32768) ? 0 : 255;
      default: return ph / 256;
    endcase
  endfunction

  task automatic reset_model();
    exp_q.delete();
    got.delete();
    model_acc  = 0;
    n_adm      = 0;
    stall_prev = 0;
  endtask

  // One clock: check the output handshake, update model, step past the edge.
  task automatic cycle();
    bit adm, take;
    int base, ph, e;
    adm  = enable && !(out_valid && !out_ready);
    take = out_valid && out_ready;
    if (stall_prev) begin
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_sample", 32'(out_sample), held);
    end
    if (take) begin
      if (exp_q.size() == 0) chk("spurious_valid", 32'(out_valid), 0);
      else begin
        e = exp_q.pop_front();
        chk("sample", 32'(out_sample), e);
        got.push_back(int'(out_sample));
      end
    end
    if (adm) begin
      base      = phase_sync ? 0 : model_acc;
      ph        = (base + int'(phase_offset)) % 65536;
      model_acc = (base + int'(ftw)) % 65536;
      exp_q.push_back(ref_sample(int'(mode), ph));
      n_adm++;
    end
    stall_prev = out_valid && !out_ready;
    held       = int'(out_sample);
    @(posedge clock);
    #1;
  endtask

  task automatic run_until(input int n, input string tag);
    for (int c = 0; c < 2000 && got.size() < n; c++) cycle();
    chk(tag, 32'(got.size() >= n), 1);
  endtask

  task automatic drain();
    enable     = 1'b0;
    phase_sync = 1'b0;
    out_ready  = 1'b1;
    repeat (6) cycle();
    chk("drained", 32'(exp_q.size()), 0);
    got.delete();
    n_adm = 0;
  endtask

  task automatic start_stream(input int m, input int f, input int off);
    mode         = 2'(m);
    ftw          = 16'(f);
    phase_offset = 16'(off);
    enable       = 1'b1;
    phase_sync   = 1'b1;
    cycle();
    phase_sync   = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; enable = 1'b0; phase_sync = 1'b0; out_ready = 1'b1;
    ftw = '0; phase_offset = '0; mode = '0;
    reset_model();

    // Reset state and idle.
    #2;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_sample", 32'(out_sample), 128);
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;
    repeat (4) cycle();
    chk("idle_valid", 32'(out_valid), 0);

    // Sine stream: latency, landmarks, back-pressure at sample #10.
    mode = 2'd0; ftw = 16'h0400; phase_offset = 16'h0000; enable = 1'b1;
    cycle(); chk("lat_edge1", 32'(out_valid), 0);
    cycle(); chk("lat_edge2", 32'(out_valid), 0);
    cycle(); chk("lat_edge3", 32'(out_valid), 1);
    run_until(10, "reach_s10");
    out_ready = 1'b0;
    repeat (5) cycle();
    out_ready = 1'b1;
    run_until(65, "reach_s65");
    chk("sine_s0",  32'(got[0]),  130);
    chk("sine_s16", 32'(got[16]), 255);
    chk("sine_s32", 32'(got[32]), 126);
    chk("sine_s48", 32'(got[48]), 1);
    chk("sine_s64", 32'(got[64]), 130);
    drain();

    // ftw=0 constant, square, triangle.
    start_stream(0, 16'h0000, 16'h8000);
    run_until(8, "reach_const");
    for (int i = 0; i < 8; i++) chk("const_sine", 32'(got[i]), 126);
    drain();
    start_stream(2, 16'h0400, 0);
    run_until(64, "reach_square");
    for (int i = 0; i < 64; i++) chk("square", 32'(got[i]), (i < 32) ? 255 : 0);
    drain();
    start_stream(1, 16'h0400, 0);
    run_until(64, "reach_tri");
    for (int i = 0; i < 64; i++) chk("triangle", 32'(got[i]), (i < 32) ? 8 * i : 255 - 8 * (i - 32));
    drain();

    // phase_sync mid-stream restarts the sequence.
    start_stream(0, 16'h0400, 0);
    run_until(20, "reach_sync");
    phase_sync = 1'b1;
    idx = n_adm;
    cycle();
    phase_sync = 1'b0;
    run_until(idx + 3, "reach_sync_after");
    chk("sync_s0", 32'(got[idx]),     130);
    chk("sync_s1", 32'(got[idx + 1]), 142);
    chk("sync_s2", 32'(got[idx + 2]), 154);

    // Asynchronous reset mid-stream, between clock edges.
    repeat (7) cycle();
    #3 reset = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 0);
    chk("async_rst_sample", 32'(out_sample), 128);
    reset_model();
    @(posedge clock); #1;
    reset = 1'b0;
    run_until(3, "reach_post_rst");
    chk("post_rst_s0", 32'(got[0]), 130);
    chk("post_rst_s1", 32'(got[1]), 142);
    drain();

    // Randomized traffic against the reference model.
    for (int n = 0; n < 800; n++) begin
      enable     = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 9) < 7);
      phase_sync = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 15) == 0) begin
        mode         = 2'($urandom_range(0, 3));
        ftw          = 16'($urandom);
        phase_offset = 16'($urandom);
      end
      cycle();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
